// File: rtl/ball_motion_engine.sv
// ball_motion_engine: one-ball-per-clock motion engine with cushion reflection and friction.
// Optional corner pockets are enabled with `define POCKET_EN.
module ball_motion_engine #(
   parameter int NUM_BALLS = 2,
   parameter int VEL_W     = 6,
   parameter int VMAX      = 12,
   parameter int FRIC_DIV  = 20,
   parameter int TBL_L     = 40,
   parameter int TBL_R     = 600,
   parameter int TBL_T     = 40,
   parameter int TBL_B     = 440,
   parameter int BALL_R    = 10,
   parameter int START_X0  = 213,
   parameter int START_DX  = 213,
   parameter int START_Y   = 240,
   parameter int POCKET_R  = 14,
   localparam int IW       = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    frame_tick,
   input  logic                    shot_valid,
   output logic                    shot_ready,
   input  logic [IW-1:0]           shot_id,
   input  logic signed [VEL_W-1:0] shot_vx,
   input  logic signed [VEL_W-1:0] shot_vy,
   output logic [10*NUM_BALLS-1:0] pos_x,
   output logic [10*NUM_BALLS-1:0] pos_y,
   output logic [NUM_BALLS-1:0]    moving,
   output logic                    busy,
   output logic                    frame_done,
   output logic                    overrun,
   output logic [NUM_BALLS-1:0]    pocketed
);

   localparam int FC_W = (FRIC_DIV > 1) ? $clog2(FRIC_DIV) : 1;
   localparam logic signed [11:0]      X_LO   = 12'(TBL_L + BALL_R);
   localparam logic signed [11:0]      X_HI   = 12'(TBL_R - BALL_R);
   localparam logic signed [11:0]      Y_LO   = 12'(TBL_T + BALL_R);
   localparam logic signed [11:0]      Y_HI   = 12'(TBL_B - BALL_R);
   localparam logic signed [VEL_W-1:0] VMAX_P = VEL_W'(VMAX);
   localparam logic signed [VEL_W-1:0] VMAX_N = VEL_W'(-VMAX);
   localparam logic signed [VEL_W-1:0] V_ONE  = VEL_W'(1);
   localparam logic [IW-1:0]           LAST   = IW'(NUM_BALLS - 1);
   localparam logic [FC_W-1:0]         F_LAST = FC_W'(FRIC_DIV - 1);

   typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_DONE} state_t;

   state_t                   state_q, state_d;
   logic [IW-1:0]            idx_q, idx_d;
   logic [FC_W-1:0]          fric_q, fric_d;
   logic [9:0]               x_q  [NUM_BALLS];
   logic [9:0]               x_d  [NUM_BALLS];
   logic [9:0]               y_q  [NUM_BALLS];
   logic [9:0]               y_d  [NUM_BALLS];
   logic signed [VEL_W-1:0]  vx_q [NUM_BALLS];
   logic signed [VEL_W-1:0]  vx_d [NUM_BALLS];
   logic signed [VEL_W-1:0]  vy_q [NUM_BALLS];
   logic signed [VEL_W-1:0]  vy_d [NUM_BALLS];
   logic [NUM_BALLS-1:0]     pocketed_q, pocketed_d;
   logic                     overrun_q, overrun_d;
   logic                     frame_done_q, frame_done_d;
   logic                     busy_q, busy_d;
   logic                     ready_q, ready_d;

   logic [9:0]               cur_x, cur_y, upd_x, upd_y;
   logic signed [VEL_W-1:0]  cur_vx, cur_vy, upd_vx, upd_vy;
   logic signed [11:0]       vx_ext, vy_ext, nx, ny;
   logic                     fric_now, pocket_hit;

   function automatic logic signed [VEL_W-1:0] clamp_v(input logic signed [VEL_W-1:0] v);
      if (v > VMAX_P)      return VMAX_P;
      else if (v < VMAX_N) return VMAX_N;
      else                 return v;
   endfunction

   function automatic logic signed [VEL_W-1:0] decay(input logic signed [VEL_W-1:0] v);
      if (v == '0)          return v;
      else if (v[VEL_W-1])  return v + V_ONE;
      else                  return v - V_ONE;
   endfunction

   // Shared datapath: select the ball at idx and compute its next state.
   always_comb begin
      cur_x  = '0;
      cur_y  = '0;
      cur_vx = '0;
      cur_vy = '0;
      for (int unsigned i = 0; i < NUM_BALLS; i++) begin
         if (idx_q == IW'(i)) begin
            cur_x  = x_q[i];
            cur_y  = y_q[i];
            cur_vx = vx_q[i];
            cur_vy = vy_q[i];
         end
      end
      vx_ext   = {{(12-VEL_W){cur_vx[VEL_W-1]}}, cur_vx};
      vy_ext   = {{(12-VEL_W){cur_vy[VEL_W-1]}}, cur_vy};
      nx       = $signed({2'b00, cur_x}) + vx_ext;
      ny       = $signed({2'b00, cur_y}) + vy_ext;
      fric_now = (fric_q == F_LAST);

      upd_x  = nx[9:0];
      upd_vx = cur_vx;
      if (nx < X_LO) begin
         upd_x  = X_LO[9:0];
         upd_vx = -cur_vx;
      end else if (nx > X_HI) begin
         upd_x  = X_HI[9:0];
         upd_vx = -cur_vx;
      end

      upd_y  = ny[9:0];
      upd_vy = cur_vy;
      if (ny < Y_LO) begin
         upd_y  = Y_LO[9:0];
         upd_vy = -cur_vy;
      end else if (ny > Y_HI) begin
         upd_y  = Y_HI[9:0];
         upd_vy = -cur_vy;
      end

      if (fric_now) begin
         upd_vx = decay(upd_vx);
         upd_vy = decay(upd_vy);
      end
   end

`ifdef POCKET_EN
   localparam logic [21:0] POCKET_R2 = 22'(POCKET_R * POCKET_R);

   function automatic logic [21:0] dist2(input logic signed [11:0] px, input logic signed [11:0] py,
                                         input int cx, input int cy);
      logic signed [11:0] dx, dy;
      logic [11:0]        ax, ay;
      dx = px - 12'(cx);
      dy = py - 12'(cy);
      ax = dx[11] ? 12'(-dx) : dx;
      ay = dy[11] ? 12'(-dy) : dy;
      return ({10'd0, ax} * {10'd0, ax}) + ({10'd0, ay} * {10'd0, ay});
   endfunction

   // Capture tests the unclamped step target; after a cushion clamp the centre
   // can never get closer than BALL_R*sqrt(2) to a corner.
   always_comb begin
      pocket_hit = (dist2(nx, ny, TBL_L, TBL_T) < POCKET_R2) ||
                   (dist2(nx, ny, TBL_R, TBL_T) < POCKET_R2) ||
                   (dist2(nx, ny, TBL_L, TBL_B) < POCKET_R2) ||
                   (dist2(nx, ny, TBL_R, TBL_B) < POCKET_R2);
   end
`else
   assign pocket_hit = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      fric_d     = fric_q;
      overrun_d  = overrun_q;
      x_d        = x_q;
      y_d        = y_q;
      vx_d       = vx_q;
      vy_d       = vy_q;
      pocketed_d = pocketed_q;

      if (ready_q && shot_valid) begin
         for (int unsigned i = 0; i < NUM_BALLS; i++) begin
            if (shot_id == IW'(i) && !pocketed_q[i]) begin
               vx_d[i] = clamp_v(shot_vx);
               vy_d[i] = clamp_v(shot_vy);
            end
         end
      end

      case (state_q)
         S_IDLE: begin
            if (frame_tick) begin
               state_d = S_UPDATE;
               idx_d   = '0;
            end
         end
         S_UPDATE: begin
            if (frame_tick) overrun_d = 1'b1;
            for (int unsigned i = 0; i < NUM_BALLS; i++) begin
               if (idx_q == IW'(i) && !pocketed_q[i]) begin
                  x_d[i] = upd_x;
                  y_d[i] = upd_y;
                  if (pocket_hit) begin
                     vx_d[i]       = '0;
                     vy_d[i]       = '0;
                     pocketed_d[i] = 1'b1;
                  end else begin
                     vx_d[i] = upd_vx;
                     vy_d[i] = upd_vy;
                  end
               end
            end
            if (idx_q == LAST) state_d = S_DONE;
            else               idx_d   = idx_q + 1'b1;
         end
         S_DONE: begin
            if (frame_tick) overrun_d = 1'b1;
            fric_d  = (fric_q == F_LAST) ? '0 : fric_q + 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      frame_done_d = (state_d == S_DONE);
      busy_d       = (state_d != S_IDLE);
      ready_d      = (state_d == S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         fric_q       <= '0;
         overrun_q    <= 1'b0;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
         ready_q      <= 1'b1;
         pocketed_q   <= '0;
         for (int unsigned i = 0; i < NUM_BALLS; i++) begin
            x_q[i]  <= 10'(START_X0 + i * START_DX);
            y_q[i]  <= 10'(START_Y);
            vx_q[i] <= '0;
            vy_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         fric_q       <= fric_d;
         overrun_q    <= overrun_d;
         frame_done_q <= frame_done_d;
         busy_q       <= busy_d;
         ready_q      <= ready_d;
         pocketed_q   <= pocketed_d;
         x_q          <= x_d;
         y_q          <= y_d;
         vx_q         <= vx_d;
         vy_q         <= vy_d;
      end
   end

   always_comb begin
      pos_x  = '0;
      pos_y  = '0;
      moving = '0;
      for (int unsigned i = 0; i < NUM_BALLS; i++) begin
         pos_x[10*i +: 10] = x_q[i];
         pos_y[10*i +: 10] = y_q[i];
         moving[i]         = (vx_q[i] != '0) || (vy_q[i] != '0);
      end
   end

   assign shot_ready = ready_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign overrun    = overrun_q;
   assign pocketed   = pocketed_q;

endmodule

// File: tb/tb_ball_motion_engine.sv
// tb_ball_motion_engine: directed bench for ball_motion_engine (NUM_BALLS=2, default build).
module tb_ball_motion_engine;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              frame_tick;
   logic              shot_valid;
   logic              shot_ready;
   logic [0:0]        shot_id;
   logic signed [5:0] shot_vx;
   logic signed [5:0] shot_vy;
   logic [19:0]       pos_x;
   logic [19:0]       pos_y;
   logic [1:0]        moving;
   logic              busy;
   logic              frame_done;
   logic              overrun;
   logic [1:0]        pocketed;

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   ball_motion_engine #(.NUM_BALLS(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .frame_tick (frame_tick),
      .shot_valid (shot_valid),
      .shot_ready (shot_ready),
      .shot_id    (shot_id),
      .shot_vx    (shot_vx),
      .shot_vy    (shot_vy),
      .pos_x      (pos_x),
      .pos_y      (pos_y),
      .moving     (moving),
      .busy       (busy),
      .frame_done (frame_done),
      .overrun    (overrun),
      .pocketed   (pocketed)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: observed no finish, required finish before 1ms");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [9:0] bx(input int i);
      return pos_x[10*i +: 10];
   endfunction

   function automatic logic [9:0] by(input int i);
      return pos_y[10*i +: 10];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d required=%0d", tag, obs, exp);
      end
   endtask

   task automatic shot(input int id, input int vx, input int vy);
      @(negedge clk);
      shot_id    = id[0:0];
      shot_vx    = vx[5:0];
      shot_vy    = vy[5:0];
      shot_valid = 1'b1;
      @(negedge clk);
      shot_valid = 1'b0;
   endtask

   task automatic run_frame(input bit with_shot, input bit check_hs);
      int c;
      @(negedge clk);
      frame_tick = 1'b1;
      if (with_shot) shot_valid = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      shot_valid = 1'b0;
      if (check_hs) begin
         chk("busy_in_update", busy, 1);
         chk("ready_in_update", shot_ready, 0);
      end
      c = 1;
      while (!frame_done && c < 20) begin
         @(negedge clk);
         c++;
      end
      chk("frame_latency", c, 3);
   endtask

   task automatic frames(input int n);
      for (int k = 0; k < n; k++) run_frame(1'b0, 1'b0);
   endtask

   initial begin
      int c;
      int dones;
      rst_n      = 1'b0;
      frame_tick = 1'b0;
      shot_valid = 1'b0;
      shot_id    = '0;
      shot_vx    = '0;
      shot_vy    = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      chk("rst_pos_x", pos_x, {10'd426, 10'd213});
      chk("rst_pos_y", pos_y, {10'd240, 10'd240});
      chk("rst_ready", shot_ready, 1);
      chk("rst_moving", moving, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_pocketed", pocketed, 0);

      // basic move and handshake timing
      shot(0, 5, -3);
      chk("moving_after_shot", moving, 2'b01);
      run_frame(1'b0, 1'b1);
      chk("f1_b0x", bx(0), 218);
      chk("f1_b0y", by(0), 237);
      chk("f1_b1x", bx(1), 426);
      chk("f1_b1y", by(1), 240);
      @(negedge clk);
      chk("done_one_cycle", frame_done, 0);
      chk("idle_ready", shot_ready, 1);
      chk("idle_busy", busy, 0);

      // velocity clamp, both signs
      shot(0, 20, 0);
      shot(1, -25, 30);
      run_frame(1'b0, 1'b0);
      chk("f2_b0x", bx(0), 230);
      chk("f2_b1x", bx(1), 414);
      chk("f2_b1y", by(1), 252);
      run_frame(1'b0, 1'b0);
      chk("f3_b0x", bx(0), 242);
      chk("f3_b1x", bx(1), 402);
      chk("f3_b1y", by(1), 264);

      // drive ball0 toward the right cushion, ball1 into the top cushion
      for (int k = 0; k < 28; k++) begin
         shot(0, 12, 0);
         shot(1, 0, -12);
         run_frame(1'b0, 1'b0);
      end
      chk("f31_b0x", bx(0), 578);
      chk("f31_b0y", by(0), 237);
      chk("f31_b1x", bx(1), 402);
      chk("f31_b1y_top", by(1), 50);
      shot(0, 7, 0);
      run_frame(1'b0, 1'b0);
      chk("f32_b0x", bx(0), 585);
      chk("f32_b1y_flip", by(1), 62);
      shot(0, 8, 0);
      run_frame(1'b0, 1'b0);
      chk("f33_b0x_right", bx(0), 590);
      chk("f33_b1y", by(1), 74);
      run_frame(1'b0, 1'b0);
      chk("f34_b0x_flip", bx(0), 582);
      chk("f34_b1y", by(1), 86);
      chk("f34_b1x", bx(1), 402);

      // friction decay from a fresh reset
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      shot(0, 3, 0);
      frames(19);
      chk("fr19_b0x", bx(0), 270);
      chk("fr19_moving", moving, 2'b01);
      run_frame(1'b0, 1'b0);
      chk("fr20_b0x", bx(0), 273);
      run_frame(1'b0, 1'b0);
      chk("fr21_b0x_v2", bx(0), 275);
      frames(38);
      chk("fr59_b0x", bx(0), 332);
      chk("fr59_moving", moving, 2'b01);
      run_frame(1'b0, 1'b0);
      chk("fr60_b0x", bx(0), 333);
      chk("fr60_moving", moving, 2'b00);

      // frame_tick during UPDATE: flagged, loop not restarted
      shot(1, 5, 0);
      chk("ov_moving", moving, 2'b10);
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      @(negedge clk);
      frame_tick = 1'b0;
      c = 2;
      while (!frame_done && c < 20) begin
         @(negedge clk);
         c++;
      end
      chk("ov_latency", c, 3);
      dones = 0;
      repeat (4) begin
         @(negedge clk);
         if (frame_done) dones++;
      end
      chk("ov_no_restart", dones, 0);
      chk("ov_busy", busy, 0);
      chk("ov_flag", overrun, 1);
      chk("ov_b1x", bx(1), 431);
      chk("ov_b0x", bx(0), 333);

      // asynchronous reset in the middle of UPDATE
      shot(0, 5, 0);
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_pos_x", pos_x, {10'd426, 10'd213});
      chk("mid_rst_pos_y", pos_y, {10'd240, 10'd240});
      chk("mid_rst_done", frame_done, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_overrun", overrun, 0);
      chk("mid_rst_moving", moving, 0);
      chk("mid_rst_ready", shot_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      repeat (6) begin
         @(negedge clk);
         if (frame_done) dones++;
      end
      chk("mid_rst_no_done", dones, 0);

      // shot and frame_tick in the same cycle: new velocity used
      shot_id = 1'b0;
      shot_vx = -6'sd7;
      shot_vy = 6'sd4;
      run_frame(1'b1, 1'b0);
      chk("same_b0x", bx(0), 206);
      chk("same_b0y", by(0), 244);
      chk("same_b1x", bx(1), 426);
      chk("same_moving", moving, 2'b01);
      chk("end_pocketed", pocketed, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ball_motion_engine.md
Name: ball_motion_engine

Overview:
- Parametrised N-ball motion engine for the billiard table.
- On every frame tick it updates each ball's centre from a signed velocity, reflects balls off the cushions, and applies friction decay.
- Cue shots enter through a valid/ready handshake. Ball centres leave as flat buses for the pixel renderer.
- Runs one ball per clock through a sequential update loop, so a single shared datapath serves all balls.

Parameters:
NUM_BALLS, 2, number of balls (1..8); index width IW = max(1, clog2(NUM_BALLS))
VEL_W, 6, signed velocity width (px/frame)
VMAX, 12, velocity magnitude clamp applied on shot load
FRIC_DIV, 20, frames between friction steps
TBL_L, 40, inner cushion left x
TBL_R, 600, inner cushion right x
TBL_T, 40, inner cushion top y
TBL_B, 440, inner cushion bottom y
BALL_R, 10, ball radius
START_X0, 213, reset x of ball 0
START_DX, 213, reset x spacing between balls
START_Y, 240, reset y of all balls
POCKET_R, 14, pocket capture radius (optional feature only)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle pulse at end of visible frame
shot_valid  in  1  shot request
shot_ready  out  1  engine can accept shot
shot_id  in  IW  target ball index
shot_vx  in  VEL_W  signed x velocity
shot_vy  in  VEL_W  signed y velocity
pos_x  out  10*NUM_BALLS  ball i centre x at [10i+9:10i]
pos_y  out  10*NUM_BALLS  ball i centre y
moving  out  NUM_BALLS  bit i = ball i has nonzero velocity
busy  out  1  update loop running
frame_done  out  1  one-cycle pulse after last ball updated
overrun  out  1  sticky: frame_tick arrived while busy
pocketed  out  NUM_BALLS  bit i = ball i captured (0 without feature)

Behaviour:
- Reset (rst_n low, async):
  - pos_x[i] = START_X0 + i*START_DX; pos_y[i] = START_Y; all velocities 0.
  - State IDLE; shot_ready=1; busy=0; frame_done=0; overrun=0; pocketed=0; friction counter 0.
  - Reset mid-update abandons the loop; no partial frame_done.
- FSM states: IDLE, UPDATE, DONE.
  - IDLE -> UPDATE on frame_tick; idx=0.
  - UPDATE processes ball idx in one cycle; idx++. After idx==NUM_BALLS-1, go to DONE.
  - DONE: frame_done=1 for one cycle -> IDLE.
  - Latency: frame_tick to frame_done = NUM_BALLS+1 cycles.
- Handshake:
  - shot_ready=1 only in IDLE.
  - Transfer when shot_valid&&shot_ready: ball shot_id velocity <= clamp(shot_vx/vy, -VMAX, +VMAX).
  - shot_id >= NUM_BALLS is accepted and discarded.
  - A shot to a pocketed ball is accepted and discarded.
  - Shot and frame_tick in the same cycle: velocity written first; UPDATE uses the new velocity.
- frame_tick while busy (UPDATE or DONE): ignored, overrun<=1. overrun is cleared only by reset.
- Per-ball update, 12-bit signed arithmetic: nx = x + vx; ny = y + vy.
  - nx < TBL_L+BALL_R: x = TBL_L+BALL_R; vx = -vx. Mirror rule at the right cushion (x = TBL_R-BALL_R). Same for y with top/bottom.
  - x and y are tested independently, so a corner hit flips both components.
  - Otherwise x=nx, y=ny.
- Friction:
  - Frame counter increments at each DONE. When it reaches FRIC_DIV-1 it wraps to 0, and that frame's UPDATE steps each nonzero vx, vy one unit toward 0, applied after the reflection.
  - Zero stays zero.
- moving[i] = (vx[i]!=0)||(vy[i]!=0), combinational from velocity registers.
- Position outputs are registered and change only in UPDATE cycles.
- No ball-ball interaction in this block; a separate collision resolver writes velocities through the shot port.

Optional Feature:
- Macro POCKET_EN.
- Defined:
  - After ball idx is updated in the same cycle, test squared distance to each corner (TBL_L,TBL_T), (TBL_R,TBL_T), (TBL_L,TBL_B), (TBL_R,TBL_B) against POCKET_R^2 (22-bit unsigned compare).
  - On a hit: pocketed[idx]<=1, velocity zeroed, position frozen at the captured value. The ball is skipped in later updates but idx still advances.
  - Ball stays pocketed until reset.
- Undefined: no distance logic; pocketed tied to 0.

Test Plan:
- Reset with NUM_BALLS=2: pos_x={426,213}, pos_y={240,240}, shot_ready=1, moving=0, overrun=0.
- Shot id0 vx=+5 vy=-3, then frame_tick: after 3 cycles frame_done pulses; ball0 at (218,237); ball1 unchanged at (426,240).
- Shot id0 vx=+20: velocity clamps to +12; ball moves 12 px per frame.
- Ball0 at x=585, vx=+8: next frame x=590, vx=-8. Repeat at top edge with vy flips.
- Ball0 vx=+3, FRIC_DIV=20: after 20 frames vx=2; after 60 frames vx=0 and moving[0]=0. frame_tick during UPDATE sets overrun=1 and does not restart the loop.
- With POCKET_EN: ball0 at (52,52), vx=vy=-4: next frame pocketed[0]=1, velocity 0; a subsequent shot to id0 is accepted with no motion. Reset mid-UPDATE returns all balls to start with frame_done=0.
